// File: rtl/sub16_serial.sv
// Multi-cycle subtractor: computes a - b CHUNK bits per cycle, LSB chunk first,
// with a registered borrow chain and a start/busy/done handshake gated by en.
module sub16_serial #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             zero,
    output logic             ovf
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NCHUNK - 1);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             w_accept;
    logic             w_step;
    logic             w_last;

    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_part;
    logic             r_bint;
    logic [CNT_W-1:0] r_cnt;
    logic             r_a_msb;
    logic             r_b_msb;
    logic             r_done;
    logic [WIDTH-1:0] r_diff;
    logic             r_borrow;
    logic             r_zero;
    logic             r_ovf;

    logic [CHUNK:0]   w_sub;
    logic [CHUNK-1:0] w_d;
    logic             w_bout;
    logic [WIDTH-1:0] w_part_nxt;

    // One chunk of the borrow chain; the extra top bit captures the chunk borrow-out.
    assign w_sub      = {1'b0, r_a_sh[CHUNK-1:0]} - {1'b0, r_b_sh[CHUNK-1:0]}
                        - {{CHUNK{1'b0}}, r_bint};
    assign w_d        = w_sub[CHUNK-1:0];
    assign w_bout     = w_sub[CHUNK];
    assign w_part_nxt = {w_d, r_part[WIDTH-1:CHUNK]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_step      = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start && en) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (en) begin
                    w_step = 1'b1;
                    if (r_cnt == LAST) begin
                        w_last      = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_sh   <= '0;
            r_b_sh   <= '0;
            r_part   <= '0;
            r_bint   <= 1'b0;
            r_cnt    <= '0;
            r_a_msb  <= 1'b0;
            r_b_msb  <= 1'b0;
            r_done   <= 1'b0;
            r_diff   <= '0;
            r_borrow <= 1'b0;
            r_zero   <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            r_done <= w_last;
            if (w_accept) begin
                r_a_sh  <= a;
                r_b_sh  <= b;
                r_a_msb <= a[WIDTH-1];
                r_b_msb <= b[WIDTH-1];
                r_bint  <= 1'b0;
                r_cnt   <= '0;
            end else if (w_step) begin
                r_a_sh <= r_a_sh >> CHUNK;
                r_b_sh <= r_b_sh >> CHUNK;
                r_part <= w_part_nxt;
                r_bint <= w_bout;
                r_cnt  <= r_cnt + 1'b1;
            end
            // Operand sign bits are kept aside because the shift registers lose them.
            if (w_last) begin
                r_diff   <= w_part_nxt;
                r_borrow <= w_bout;
                r_zero   <= (w_part_nxt == '0);
                r_ovf    <= (r_a_msb != r_b_msb) && (w_part_nxt[WIDTH-1] != r_a_msb);
            end
        end
    end

    assign busy   = (r_state == S_RUN);
    assign done   = r_done;
    assign diff   = r_diff;
    assign borrow = r_borrow;
    assign zero   = r_zero;
    assign ovf    = r_ovf;

endmodule

// File: tb/tb_sub16_serial.sv
// Scoreboard bench for sub16_serial: expected results are queued at each start and
// popped whenever done pulses.
module tb_sub16_serial;

    typedef struct packed {
        logic [15:0] d;
        logic        br;
        logic        z;
        logic        ov;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        busy;
    logic        done;
    logic [15:0] diff;
    logic        borrow;
    logic        zero;
    logic        ovf;

    exp_t sb[$];
    int   n_cmp    = 0;
    int   n_err    = 0;
    int   n_done   = 0;
    int   n_expect = 0;
    logic prev_done = 1'b0;

    sub16_serial #(.WIDTH(16), .CHUNK(4)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (en),
        .start  (start),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .diff   (diff),
        .borrow (borrow),
        .zero   (zero),
        .ovf    (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [15:0] ia, input logic [15:0] ib);
        exp_t e;
        e.d  = ia - ib;
        e.br = (ia < ib);
        e.z  = (e.d == 16'h0000);
        e.ov = (ia[15] != ib[15]) && (e.d[15] != ia[15]);
        return e;
    endfunction

    // Drives one start pulse and queues the expected result; returns just after the accepting edge.
    task automatic start_op(input logic [15:0] ia, input logic [15:0] ib);
        @(posedge clk);
        #1;
        a = ia;
        b = ib;
        start = 1'b1;
        sb.push_back(model(ia, ib));
        n_expect++;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = 16'($urandom);
        b = 16'($urandom);
    endtask

    task automatic wait_done(input int exp_lat);
        int n = 0;
        logic got = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (done) begin
                got = 1'b1;
                break;
            end
            check("busy_run", 32'(busy), 32'd1);
            n++;
        end
        check("done_seen", 32'(got), 32'd1);
        if (got) begin
            check("latency", 32'(n), 32'(exp_lat));
            check("busy_at_done", 32'(busy), 32'd0);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_busy"},   32'(busy),   32'd0);
        check({tag, "_done"},   32'(done),   32'd0);
        check({tag, "_diff"},   32'(diff),   32'd0);
        check({tag, "_borrow"}, 32'(borrow), 32'd0);
        check({tag, "_zero"},   32'(zero),   32'd0);
        check({tag, "_ovf"},    32'(ovf),    32'd0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (done) begin
                n_done++;
                check("done_width", 32'(prev_done), 32'd0);
                check("sb_nonempty", 32'(sb.size() > 0), 32'd1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check("diff",   32'(diff),   32'(e.d));
                    check("borrow", 32'(borrow), 32'(e.br));
                    check("zero",   32'(zero),   32'(e.z));
                    check("ovf",    32'(ovf),    32'(e.ov));
                end
            end
            prev_done = done;
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        rst_n = 1'b0;
        en    = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        #1;
        check_outputs_zero("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // T1 basic
        start_op(16'h1234, 16'h0234);
        wait_done(4);

        // T2 borrow and signed overflow
        start_op(16'h0000, 16'h0001);
        wait_done(4);
        start_op(16'h8000, 16'h0001);
        wait_done(4);

        // T3 zero result, then back-to-back start in the done cycle
        start_op(16'hBEEF, 16'hBEEF);
        wait_done(4);
        a = 16'h0005;
        b = 16'h0007;
        start = 1'b1;
        sb.push_back(model(16'h0005, 16'h0007));
        n_expect++;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("b2b_busy", 32'(busy), 32'd1);
        check("hold_at_start_diff", 32'(diff), 32'h0000);
        check("hold_at_start_zero", 32'(zero), 32'd1);
        wait_done(4);

        // T4 three-cycle en stall mid-run
        start_op(16'h1234, 16'h0234);
        fork
            begin
                @(posedge clk);
                #1;
                en = 1'b0;
                repeat (3) @(posedge clk);
                #1;
                en = 1'b1;
            end
        join_none
        wait_done(7);

        // T5 start while busy is ignored
        start_op(16'h1234, 16'h0234);
        fork
            begin
                @(posedge clk);
                #1;
                a = 16'hFFFF;
                b = 16'h0000;
                start = 1'b1;
                @(posedge clk);
                #1;
                start = 1'b0;
            end
        join_none
        wait_done(4);
        repeat (6) @(negedge clk);
        check("t5_idle", 32'(busy), 32'd0);

        // start with en low in IDLE is not accepted
        @(posedge clk);
        #1;
        en = 1'b0;
        start = 1'b1;
        a = 16'h0001;
        b = 16'h0002;
        @(posedge clk);
        #1;
        en = 1'b1;
        start = 1'b0;
        repeat (6) begin
            @(negedge clk);
            check("no_accept_en0", 32'(busy), 32'd0);
        end

        // random operands
        for (int i = 0; i < 4; i++) begin
            start_op(16'($urandom), 16'($urandom));
            wait_done(4);
        end

        // T6 reset mid-run drops the operation
        start_op(16'h1234, 16'h0234);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_outputs_zero("midrun_reset");
        void'(sb.pop_back());
        n_expect--;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (8) begin
            @(negedge clk);
            check("post_reset_idle", 32'(busy), 32'd0);
        end

        // recovery after reset
        start_op(16'h1234, 16'h0234);
        wait_done(4);
        repeat (3) @(negedge clk);

        check("sb_empty", 32'(sb.size()), 32'd0);
        check("done_count", 32'(n_done), 32'(n_expect));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
